execute_cycle: RTL and testbench



---
 rtl/riscv_pkg.sv | 31 +++
 rtl/execute_cycle_alu.sv | 53 +++++
 rtl/execute_cycle.sv | 218 +++++++++++++++++++++
 tb/tb_execute_cycle.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the execute stage: ALU operations, branch funct3
// values and operand-forwarding selects.
package riscv_pkg;

  // ALU operation codes carried by ALUControlE
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  // Conditional-branch funct3 (InstrE[14:12]); 010/011 are never taken
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Forwarding selects; 11 falls back to the register-file value
  localparam logic [1:0] FWD_RD      = 2'b00;
  localparam logic [1:0] FWD_RESULTW = 2'b01;
  localparam logic [1:0] FWD_ALUM    = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational 32-bit ALU. The comparison flags look at a_i against
// cmp_b_i (the forwarded rs2), which is independent of the immediate mux so
// branch decisions never see the immediate.
module alu
  import riscv_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] cmp_b_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        lt_o,
  output logic        ltu_o
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] cmp_b_s;
  logic        [4:0]  shamt;

  assign a_s     = a_i;
  assign b_s     = b_i;
  assign cmp_b_s = cmp_b_i;
  assign shamt   = b_i[4:0];

  // Arithmetic/logic result; unassigned op codes produce zero
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SLT:   result_o = {31'b0, (a_s < b_s)};
      ALU_SLTU:  result_o = {31'b0, (a_i < b_i)};
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SRL:   result_o = a_i >> shamt;
      ALU_SRA:   result_o = a_s >>> shamt;
      ALU_PASSB: result_o = b_i;
      default:   result_o = '0;
    endcase
  end

  // Branch comparison flags against the forwarded rs2 value
  always_comb begin
    zero_o = (a_i == cmp_b_i);
    lt_o   = (a_s < cmp_b_s);
    ltu_o  = (a_i < cmp_b_i);
  end

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: forwarding, ALU, AUIPC sum, branch/jump resolution,
// misprediction detection, predictor update, E/M register and saturating
// branch/mispredict performance counters.
module execute_cycle
  import riscv_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PERF_EN = 1
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic [1:0]       ResultSrcE,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             JalrE,
  input  logic             LuiE,
  input  logic             ALUSrcE,
  input  logic [3:0]       ALUControlE,
  input  logic [31:0]      RD1E,
  input  logic [31:0]      RD2E,
  input  logic [31:0]      ImmExtE,
  input  logic [31:0]      PCE,
  input  logic [31:0]      PCPlus4E,
  input  logic [31:0]      InstrE,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [31:0]      ResultW,
  input  logic             PredTakenE,
  input  logic [31:0]      PredTargetE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             LuiM,
  output logic [1:0]       ResultSrcM,
  output logic [31:0]      ALUResultM,
  output logic [31:0]      WriteDataM,
  output logic [31:0]      PCPlus4M,
  output logic [31:0]      InstrM,
  output logic [31:0]      AuLu_ResultM,
  output logic [4:0]       RdM,
  output logic             MispredictE,
  output logic [31:0]      RedirectPCE,
  output logic             BpUpdateE,
  output logic             BpTakenE,
  output logic [31:0]      BpPCE,
  output logic [31:0]      BpTargetE,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] MispredCnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating increment: an all-ones counter stays put
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Three-way forwarding select; the unused 11 code reads the register file
  function automatic logic [31:0] fwd_sel(input logic [1:0]  sel,
                                          input logic [31:0] rd,
                                          input logic [31:0] res_w,
                                          input logic [31:0] alu_m);
    case (sel)
      FWD_RESULTW: return res_w;
      FWD_ALUM:    return alu_m;
      default:     return rd;
    endcase
  endfunction

  // E/M register state
  logic             reg_write_q;
  logic             mem_write_q;
  logic             lui_q;
  logic [1:0]       result_src_q;
  logic [31:0]      alu_result_q;
  logic [31:0]      write_data_q;
  logic [31:0]      pc_plus4_q;
  logic [31:0]      instr_q;
  logic [31:0]      aulu_q;
  logic [4:0]       rd_q;

  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_d;

  // Execute-stage combinational datapath
  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic [31:0] aulu_result;
  logic [31:0] target;
  logic        flag_eq;
  logic        flag_lt;
  logic        flag_ltu;
  logic        cond;
  logic        taken;
  logic        is_ctrl;
  logic        mispredict;

  assign src_a       = fwd_sel(ForwardAE, RD1E, ResultW, alu_result_q);
  assign fwd_b       = fwd_sel(ForwardBE, RD2E, ResultW, alu_result_q);
  assign src_b       = ALUSrcE ? ImmExtE : fwd_b;
  assign aulu_result = PCE + ImmExtE;

  alu u_alu (
    .op_i     (ALUControlE),
    .a_i      (src_a),
    .b_i      (src_b),
    .cmp_b_i  (fwd_b),
    .result_o (alu_result),
    .zero_o   (flag_eq),
    .lt_o     (flag_lt),
    .ltu_o    (flag_ltu)
  );

  // Branch condition from funct3 on the forwarded operands
  always_comb begin
    cond = 1'b0;
    case (InstrE[14:12])
      F3_BEQ:  cond = flag_eq;
      F3_BNE:  cond = ~flag_eq;
      F3_BLT:  cond = flag_lt;
      F3_BGE:  cond = ~flag_lt;
      F3_BLTU: cond = flag_ltu;
      F3_BGEU: cond = ~flag_ltu;
      default: cond = 1'b0;
    endcase
  end

  // Outcome, target and misprediction; JALR clears bit 0 of rs1+imm
  always_comb begin
    taken      = ValidE & (JumpE | (BranchE & cond));
    target     = JalrE ? ((src_a + ImmExtE) & ~32'h1) : aulu_result;
    is_ctrl    = BranchE | JumpE;
    mispredict = ValidE & (is_ctrl | PredTakenE) &
                 ((taken != PredTakenE) | (taken & (PredTargetE != target)));
  end

  assign MispredictE = mispredict;
  assign RedirectPCE = taken ? target : PCPlus4E;
  assign BpUpdateE   = ValidE & is_ctrl;
  assign BpTakenE    = taken;
  assign BpPCE       = PCE;
  assign BpTargetE   = target;

  // ---- E/M pipeline boundary ----
  // Controls are squashed on bubbles; data fields load unconditionally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      lui_q        <= 1'b0;
      result_src_q <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      instr_q      <= '0;
      aulu_q       <= '0;
      rd_q         <= '0;
    end else begin
      reg_write_q  <= ValidE & RegWriteE;
      mem_write_q  <= ValidE & MemWriteE;
      lui_q        <= ValidE & LuiE;
      result_src_q <= ResultSrcE;
      alu_result_q <= alu_result;
      write_data_q <= fwd_b;
      pc_plus4_q   <= PCPlus4E;
      instr_q      <= InstrE;
      aulu_q       <= aulu_result;
      rd_q         <= RdE;
    end
  end

  assign RegWriteM    = reg_write_q;
  assign MemWriteM    = mem_write_q;
  assign LuiM         = lui_q;
  assign ResultSrcM   = result_src_q;
  assign ALUResultM   = alu_result_q;
  assign WriteDataM   = write_data_q;
  assign PCPlus4M     = pc_plus4_q;
  assign InstrM       = instr_q;
  assign AuLu_ResultM = aulu_q;
  assign RdM          = rd_q;

  // Next counter values; disabled counters are pinned at zero
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (PERF_EN == 0) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else begin
      if (BpUpdateE)  branch_cnt_d  = sat_inc(branch_cnt_q);
      if (mispredict) mispred_cnt_d = sat_inc(mispred_cnt_q);
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BranchCnt  = branch_cnt_q;
  assign MispredCnt = mispred_cnt_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: a reference model checked every cycle plus
// directed vectors with hand-computed expectations. A second instance with
// 4-bit counters exercises counter saturation.
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic        ValidE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE, LuiE, ALUSrcE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, InstrE, ResultW, PredTargetE;
  logic [4:0]  RdE;
  logic        PredTakenE;

  logic        RegWriteM, MemWriteM, LuiM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, InstrM, AuLu_ResultM;
  logic [4:0]  RdM;
  logic        MispredictE, BpUpdateE, BpTakenE;
  logic [31:0] RedirectPCE, BpPCE, BpTargetE;
  logic [31:0] BranchCnt, MispredCnt;

  logic        s_RegWriteM, s_MemWriteM, s_LuiM;
  logic [1:0]  s_ResultSrcM;
  logic [31:0] s_ALUResultM, s_WriteDataM, s_PCPlus4M, s_InstrM, s_AuLu_ResultM;
  logic [4:0]  s_RdM;
  logic        s_MispredictE, s_BpUpdateE, s_BpTakenE;
  logic [31:0] s_RedirectPCE, s_BpPCE, s_BpTargetE;
  logic [3:0]  s_BranchCnt, s_MispredCnt;

  int checks = 0;
  int errors = 0;

  execute_cycle #(.CNT_W(32), .PERF_EN(1)) dut (
    .clk(clk), .rst(rst), .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .LuiE(LuiE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .InstrE(InstrE), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .LuiM(LuiM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .InstrM(InstrM),
    .AuLu_ResultM(AuLu_ResultM), .RdM(RdM), .MispredictE(MispredictE),
    .RedirectPCE(RedirectPCE), .BpUpdateE(BpUpdateE), .BpTakenE(BpTakenE),
    .BpPCE(BpPCE), .BpTargetE(BpTargetE), .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
  );

  execute_cycle #(.CNT_W(4), .PERF_EN(1)) dut4 (
    .clk(clk), .rst(rst), .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .LuiE(LuiE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .InstrE(InstrE), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .RegWriteM(s_RegWriteM), .MemWriteM(s_MemWriteM), .LuiM(s_LuiM), .ResultSrcM(s_ResultSrcM),
    .ALUResultM(s_ALUResultM), .WriteDataM(s_WriteDataM), .PCPlus4M(s_PCPlus4M),
    .InstrM(s_InstrM), .AuLu_ResultM(s_AuLu_ResultM), .RdM(s_RdM),
    .MispredictE(s_MispredictE), .RedirectPCE(s_RedirectPCE), .BpUpdateE(s_BpUpdateE),
    .BpTakenE(s_BpTakenE), .BpPCE(s_BpPCE), .BpTargetE(s_BpTargetE),
    .BranchCnt(s_BranchCnt), .MispredCnt(s_MispredCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_rw, m_mw, m_lui;
  logic [1:0]  m_rs;
  logic [31:0] m_alu, m_wd, m_pc4, m_instr, m_aulu;
  logic [4:0]  m_rd;
  longint      m_bcnt, m_mcnt, m_bcnt4, m_mcnt4;

  initial begin
    m_rw = 0; m_mw = 0; m_lui = 0; m_rs = 0; m_alu = 0; m_wd = 0;
    m_pc4 = 0; m_instr = 0; m_aulu = 0; m_rd = 0;
    m_bcnt = 0; m_mcnt = 0; m_bcnt4 = 0; m_mcnt4 = 0;
  end

  function automatic logic [31:0] ref_fwd(input logic [1:0] s, input logic [31:0] rd);
    if (s == 2'b01) return ResultW;
    if (s == 2'b10) return m_alu;
    return rd;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    longint sa;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      4'd6:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9:  return 32'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic ev(output logic [31:0] alu_r, output logic [31:0] wd,
                    output logic [31:0] aulu, output logic [31:0] tgt,
                    output logic [31:0] redir, output logic tk,
                    output logic mis, output logic bpu);
    logic [31:0] a, fb, b;
    longint sa, sb;
    logic c;
    a  = ref_fwd(ForwardAE, RD1E);
    fb = ref_fwd(ForwardBE, RD2E);
    b  = ALUSrcE ? ImmExtE : fb;
    alu_r = ref_alu(ALUControlE, a, b);
    wd   = fb;
    aulu = PCE + ImmExtE;
    sa = longint'($signed(a));
    sb = longint'($signed(fb));
    case (InstrE[14:12])
      3'd0: c = (a == fb);
      3'd1: c = (a != fb);
      3'd4: c = (sa < sb);
      3'd5: c = (sa >= sb);
      3'd6: c = (longint'(a) < longint'(fb));
      3'd7: c = (longint'(a) >= longint'(fb));
      default: c = 1'b0;
    endcase
    tk  = ValidE && (JumpE || (BranchE && c));
    tgt = JalrE ? ((a + ImmExtE) & 32'hFFFF_FFFE) : (PCE + ImmExtE);
    if (!ValidE) mis = 1'b0;
    else if (!(BranchE || JumpE || PredTakenE)) mis = 1'b0;
    else mis = (tk != PredTakenE) || (tk && (PredTargetE != tgt));
    redir = tk ? tgt : PCPlus4E;
    bpu   = ValidE && (BranchE || JumpE);
  endtask

  // Model of the registered state
  always @(posedge clk or posedge rst) begin
    logic [31:0] alu_r, wd, aulu, tgt, redir;
    logic tk, mis, bpu;
    if (rst) begin
      m_rw <= 0; m_mw <= 0; m_lui <= 0; m_rs <= 0; m_alu <= 0; m_wd <= 0;
      m_pc4 <= 0; m_instr <= 0; m_aulu <= 0; m_rd <= 0;
      m_bcnt <= 0; m_mcnt <= 0; m_bcnt4 <= 0; m_mcnt4 <= 0;
    end else begin
      ev(alu_r, wd, aulu, tgt, redir, tk, mis, bpu);
      m_rw <= ValidE && RegWriteE;
      m_mw <= ValidE && MemWriteE;
      m_lui <= ValidE && LuiE;
      m_rs <= ResultSrcE; m_alu <= alu_r; m_wd <= wd; m_pc4 <= PCPlus4E;
      m_instr <= InstrE; m_aulu <= aulu; m_rd <= RdE;
      if (bpu) begin
        m_bcnt  <= (m_bcnt  >= 64'hFFFF_FFFF) ? m_bcnt  : m_bcnt + 1;
        m_bcnt4 <= (m_bcnt4 >= 15) ? m_bcnt4 : m_bcnt4 + 1;
      end
      if (mis) begin
        m_mcnt  <= (m_mcnt  >= 64'hFFFF_FFFF) ? m_mcnt  : m_mcnt + 1;
        m_mcnt4 <= (m_mcnt4 >= 15) ? m_mcnt4 : m_mcnt4 + 1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [31:0] alu_r, wd, aulu, tgt, redir;
    logic tk, mis, bpu;
    ev(alu_r, wd, aulu, tgt, redir, tk, mis, bpu);
    chk("cyc_MispredictE", {31'b0, MispredictE}, {31'b0, mis});
    chk("cyc_RedirectPCE", RedirectPCE, redir);
    chk("cyc_BpUpdateE", {31'b0, BpUpdateE}, {31'b0, bpu});
    chk("cyc_BpTakenE", {31'b0, BpTakenE}, {31'b0, tk});
    chk("cyc_BpPCE", BpPCE, PCE);
    chk("cyc_BpTargetE", BpTargetE, tgt);
    chk("cyc_RegWriteM", {31'b0, RegWriteM}, {31'b0, m_rw});
    chk("cyc_MemWriteM", {31'b0, MemWriteM}, {31'b0, m_mw});
    chk("cyc_LuiM", {31'b0, LuiM}, {31'b0, m_lui});
    chk("cyc_ResultSrcM", {30'b0, ResultSrcM}, {30'b0, m_rs});
    chk("cyc_ALUResultM", ALUResultM, m_alu);
    chk("cyc_WriteDataM", WriteDataM, m_wd);
    chk("cyc_PCPlus4M", PCPlus4M, m_pc4);
    chk("cyc_InstrM", InstrM, m_instr);
    chk("cyc_AuLu_ResultM", AuLu_ResultM, m_aulu);
    chk("cyc_RdM", {27'b0, RdM}, {27'b0, m_rd});
    chk("cyc_BranchCnt", BranchCnt, 32'(m_bcnt));
    chk("cyc_MispredCnt", MispredCnt, 32'(m_mcnt));
    chk("cyc_BranchCnt4", {28'b0, s_BranchCnt}, 32'(m_bcnt4));
    chk("cyc_MispredCnt4", {28'b0, s_MispredCnt}, 32'(m_mcnt4));
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ValidE = 0; RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; JumpE = 0;
    JalrE = 0; LuiE = 0; ALUSrcE = 0; ALUControlE = 0; RD1E = 0; RD2E = 0; ImmExtE = 0;
    PCE = 0; PCPlus4E = 0; InstrE = 0; RdE = 0; ForwardAE = 0; ForwardBE = 0;
    ResultW = 0; PredTakenE = 0; PredTargetE = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_RegWriteM", {31'b0, RegWriteM}, 32'd0);
    chk("rst_ALUResultM", ALUResultM, 32'd0);
    chk("rst_BranchCnt", BranchCnt, 32'd0);
    #1 rst = 1'b0;
    step();

    // add 0x0C + imm 4 -> 0x10, then sub with ALUResultM forwarded as SrcA
    ValidE = 1; RegWriteE = 1; RdE = 5'd7; ALUSrcE = 1; ALUControlE = 4'b0000;
    RD1E = 32'h0C; ImmExtE = 32'h4;
    step();
    chk("add_ALUResultM", ALUResultM, 32'h10);
    chk("add_RegWriteM", {31'b0, RegWriteM}, 32'd1);
    chk("add_RdM", {27'b0, RdM}, 32'd7);
    ALUSrcE = 0; ALUControlE = 4'b0001; RD1E = 32'h5; RD2E = 32'h3; ForwardAE = 2'b10;
    step();
    chk("fwd_sub_ALUResultM", ALUResultM, 32'h0D);

    // sra by 4 with rs2 forwarded from W into the store data
    ForwardAE = 2'b00; ALUSrcE = 1; ALUControlE = 4'b1001; RD1E = 32'h8000_0000;
    ImmExtE = 32'h4; ForwardBE = 2'b01; ResultW = 32'hAB; RD2E = 32'h55;
    step();
    chk("sra_ALUResultM", ALUResultM, 32'hF800_0000);
    chk("fwdW_WriteDataM", WriteDataM, 32'hAB);

    // beq taken, correctly predicted
    idle();
    ValidE = 1; BranchE = 1; InstrE = 32'h0000_0063; RD1E = 32'd7; RD2E = 32'd7;
    PCE = 32'h100; PCPlus4E = 32'h104; ImmExtE = 32'h8; PredTakenE = 1; PredTargetE = 32'h108;
    #1;
    chk("beq_MispredictE", {31'b0, MispredictE}, 32'd0);
    chk("beq_BpUpdateE", {31'b0, BpUpdateE}, 32'd1);
    chk("beq_BpTargetE", BpTargetE, 32'h108);
    chk("beq_BranchCnt_before", BranchCnt, 32'd0);
    step();
    chk("beq_BranchCnt_after", BranchCnt, 32'd1);
    chk("beq_AuLu_ResultM", AuLu_ResultM, 32'h108);

    // blt -1 < 1 taken but predicted not taken
    idle();
    ValidE = 1; BranchE = 1; InstrE = 32'h0000_4063; RD1E = 32'hFFFF_FFFF; RD2E = 32'd1;
    PCE = 32'h200; PCPlus4E = 32'h204; ImmExtE = 32'h20; PredTakenE = 0;
    #1;
    chk("blt_MispredictE", {31'b0, MispredictE}, 32'd1);
    chk("blt_RedirectPCE", RedirectPCE, 32'h220);
    step();
    chk("blt_MispredCnt", MispredCnt, 32'd1);
    chk("blt_BranchCnt", BranchCnt, 32'd2);

    // JALR: target clears bit 0; then a wrong predicted target
    idle();
    ValidE = 1; JumpE = 1; JalrE = 1; RD1E = 32'h1003; ImmExtE = 32'h4;
    PCE = 32'h300; PCPlus4E = 32'h304; PredTakenE = 1; PredTargetE = 32'h1006;
    #1;
    chk("jalr_BpTargetE", BpTargetE, 32'h1006);
    chk("jalr_ok_MispredictE", {31'b0, MispredictE}, 32'd0);
    PredTargetE = 32'h1008;
    #1;
    chk("jalr_bad_MispredictE", {31'b0, MispredictE}, 32'd1);
    chk("jalr_bad_RedirectPCE", RedirectPCE, 32'h1006);
    step();
    chk("jalr_BranchCnt", BranchCnt, 32'd3);
    chk("jalr_MispredCnt", MispredCnt, 32'd2);

    // Predicted taken on a non-control instruction
    idle();
    ValidE = 1; PCE = 32'h400; PCPlus4E = 32'h404; PredTakenE = 1; PredTargetE = 32'h800;
    #1;
    chk("nonctl_MispredictE", {31'b0, MispredictE}, 32'd1);
    chk("nonctl_RedirectPCE", RedirectPCE, 32'h404);
    chk("nonctl_BpUpdateE", {31'b0, BpUpdateE}, 32'd0);
    step();
    chk("nonctl_MispredCnt", MispredCnt, 32'd3);

    // Asynchronous reset mid-stream drops in-flight state
    idle();
    ValidE = 1; RegWriteE = 1; MemWriteE = 1; ALUSrcE = 1; ImmExtE = 32'h99; ALUControlE = 4'b1010;
    step();
    chk("pre_rst_ALUResultM", ALUResultM, 32'h99);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_RegWriteM", {31'b0, RegWriteM}, 32'd0);
    chk("mid_rst_ALUResultM", ALUResultM, 32'd0);
    chk("mid_rst_BranchCnt", BranchCnt, 32'd0);
    chk("mid_rst_MispredCnt", MispredCnt, 32'd0);
    #1 rst = 1'b0;
    step();

    // Bubble: controls squashed, data still loads
    idle();
    ValidE = 0; RegWriteE = 1; MemWriteE = 1; LuiE = 1; ALUSrcE = 1; RD1E = 32'd1; ImmExtE = 32'd2;
    step();
    chk("bubble_RegWriteM", {31'b0, RegWriteM}, 32'd0);
    chk("bubble_MemWriteM", {31'b0, MemWriteM}, 32'd0);
    chk("bubble_LuiM", {31'b0, LuiM}, 32'd0);
    chk("bubble_ALUResultM", ALUResultM, 32'd3);

    // 17 not-taken, correctly predicted branches: 4-bit counter saturates
    idle();
    ValidE = 1; BranchE = 1; InstrE = 32'h0000_2063; PCE = 32'h500; PCPlus4E = 32'h504;
    for (int i = 0; i < 17; i++) step();
    chk("sat_BranchCnt4", {28'b0, s_BranchCnt}, 32'd15);
    chk("sat_BranchCnt32", BranchCnt, 32'd17);
    chk("sat_MispredCnt4", {28'b0, s_MispredCnt}, 32'd0);

    idle();
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
